// File: rtl/viterbi_err_injector.sv
// Channel error injector between the convolutional encoder and the Viterbi decoder.
// Forwards symbols with one cycle of latency and corrupts selected ones inside a bounded run window.
module viterbi_err_injector #(
    parameter int SYM_W  = 2,
    parameter int N      = 4,
    parameter int BL_W   = 4,
    parameter int WINDOW = 256,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [SYM_W-1:0] err_mask_i,
    input  logic [BL_W-1:0]  burst_len_i,
    input  logic [15:0]      thresh_i,
    input  logic [15:0]      seed_i,
    input  logic             valid_i,
    input  logic [SYM_W-1:0] sym_i,
    output logic             valid_o,
    output logic [SYM_W-1:0] sym_o,
    output logic             err_o,
    output logic [CNT_W-1:0] sym_ct_o,
    output logic [CNT_W-1:0] inj_ct_o,
    output logic [CNT_W-1:0] bit_ct_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int PW = ((BL_W > N) ? BL_W : N) + 1;
    localparam logic [PW-1:0] PERIOD = PW'(2 ** N);
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(WINDOW - 1);

    state_t             state_q;
    logic [1:0]         mode_q;
    logic [SYM_W-1:0]   mask_q;
    logic [BL_W-1:0]    bl_q;
    logic [15:0]        thresh_q;
    logic [15:0]        lfsr_q;
    logic               valid_q;
    logic [SYM_W-1:0]   sym_q;
    logic               err_q;
    logic [CNT_W-1:0]   sym_ct_q;
    logic [CNT_W-1:0]   inj_ct_q;
    logic [CNT_W-1:0]   bit_ct_q;
    logic               busy_q;
    logic               done_q;

    logic [N-1:0]       k_low;
    logic [PW-1:0]      l_ext;
    logic [PW-1:0]      l_eff;
    logic               burst_hit;
    logic               inject;
    logic               lfsr_fb;
    logic [15:0]        lfsr_d;
    logic [CNT_W-1:0]   mask_pop;
    logic [CNT_W:0]     bit_sum;
    logic [CNT_W-1:0]   bit_ct_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign k_low = sym_ct_q[N-1:0];
    assign l_ext = PW'(bl_q);

    // Burst length: zero acts as one, anything beyond the period covers the whole period.
    always_comb begin
        l_eff = l_ext;
        if (l_ext == '0) begin
            l_eff = PW'(1);
        end else if (l_ext > PERIOD) begin
            l_eff = PERIOD;
        end
    end

    assign burst_hit = (PW'(k_low) >= (PERIOD - l_eff));

    always_comb begin
        inject = 1'b0;
        case (mode_q)
            2'd1:    inject = &k_low;
            2'd2:    inject = burst_hit;
            2'd3:    inject = (lfsr_q < thresh_q);
            default: inject = 1'b0;
        endcase
    end

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lfsr_d  = {lfsr_q[14:0], lfsr_fb};

    always_comb begin
        mask_pop = '0;
        for (int i = 0; i < SYM_W; i++) begin
            mask_pop = mask_pop + CNT_W'(mask_q[i]);
        end
    end

    assign bit_sum  = {1'b0, bit_ct_q} + {1'b0, mask_pop};
    assign bit_ct_d = bit_sum[CNT_W] ? {CNT_W{1'b1}} : bit_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= '0;
            mask_q   <= '0;
            bl_q     <= '0;
            thresh_q <= '0;
            lfsr_q   <= 16'h0001;
            valid_q  <= 1'b0;
            sym_q    <= '0;
            err_q    <= 1'b0;
            sym_ct_q <= '0;
            inj_ct_q <= '0;
            bit_ct_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (start_i) begin
            // Start wins over a coincident symbol: it passes clean and is not counted.
            mode_q   <= mode_i;
            mask_q   <= err_mask_i;
            bl_q     <= burst_len_i;
            thresh_q <= thresh_i;
            lfsr_q   <= (seed_i == 16'h0000) ? 16'h0001 : seed_i;
            sym_ct_q <= '0;
            inj_ct_q <= '0;
            bit_ct_q <= '0;
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            valid_q  <= valid_i;
            err_q    <= 1'b0;
            if (valid_i) begin
                sym_q <= sym_i;
            end
        end else begin
            valid_q <= valid_i;
            err_q   <= 1'b0;
            if (valid_i) begin
                sym_q <= sym_i;
            end
            if (state_q == S_RUN && valid_i) begin
                lfsr_q   <= lfsr_d;
                sym_ct_q <= sat_inc(sym_ct_q);
                if (inject) begin
                    sym_q    <= sym_i ^ mask_q;
                    err_q    <= 1'b1;
                    inj_ct_q <= sat_inc(inj_ct_q);
                    bit_ct_q <= bit_ct_d;
                end
                if (sym_ct_q == LAST_K) begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign valid_o  = valid_q;
    assign sym_o    = sym_q;
    assign err_o    = err_q;
    assign sym_ct_o = sym_ct_q;
    assign inj_ct_o = inj_ct_q;
    assign bit_ct_o = bit_ct_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_viterbi_err_injector.sv
// Directed self-checking bench for viterbi_err_injector.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_viterbi_err_injector;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [1:0]  mode_i;
    logic [1:0]  err_mask_i;
    logic [3:0]  burst_len_i;
    logic [15:0] thresh_i;
    logic [15:0] seed_i;
    logic        valid_i;
    logic [1:0]  sym_i;
    logic        valid_o;
    logic [1:0]  sym_o;
    logic        err_o;
    logic [15:0] sym_ct_o;
    logic [15:0] inj_ct_o;
    logic [15:0] bit_ct_o;
    logic        busy_o;
    logic        done_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    viterbi_err_injector #(
        .SYM_W(2), .N(4), .BL_W(4), .WINDOW(256), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
        .err_mask_i(err_mask_i), .burst_len_i(burst_len_i), .thresh_i(thresh_i),
        .seed_i(seed_i), .valid_i(valid_i), .sym_i(sym_i), .valid_o(valid_o),
        .sym_o(sym_o), .err_o(err_o), .sym_ct_o(sym_ct_o), .inj_ct_o(inj_ct_o),
        .bit_ct_o(bit_ct_o), .busy_o(busy_o), .done_o(done_o)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Config inputs are scrambled after the start edge so only latched values can matter.
    task automatic start_run(input logic [1:0] m, input logic [1:0] mk, input logic [3:0] bl,
                             input logic [15:0] th, input logic [15:0] sd,
                             input logic v, input logic [1:0] s);
        mode_i = m; err_mask_i = mk; burst_len_i = bl; thresh_i = th; seed_i = sd;
        start_i = 1'b1; valid_i = v; sym_i = s;
        cyc();
        start_i = 1'b0; valid_i = 1'b0;
        mode_i = ~m; err_mask_i = ~mk; burst_len_i = ~bl; thresh_i = ~th; seed_i = ~sd;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; mode_i = '0; err_mask_i = '0; burst_len_i = '0;
        thresh_i = '0; seed_i = '0; valid_i = 1'b0; sym_i = '0;
        #12;
        n_tests++;
        if ({valid_o, sym_o, err_o, busy_o, done_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b exp 000000", {valid_o, sym_o, err_o, busy_o, done_o});
        end
        n_tests++;
        if ({sym_ct_o, inj_ct_o, bit_ct_o} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_counts got %0d/%0d/%0d exp 0/0/0", sym_ct_o, inj_ct_o, bit_ct_o);
        end
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_periodic();
        logic e;
        start_run(2'd1, 2'b11, 4'd0, 16'h0, 16'h0, 1'b0, 2'b00);
        n_tests++;
        if ({busy_o, done_o, valid_o} !== 3'b100 || sym_ct_o !== 16'd0) begin
            n_fail++;
            $display("FAIL periodic_start got b/d/v=%b ct=%0d exp 100 ct=0", {busy_o, done_o, valid_o}, sym_ct_o);
        end
        for (int k = 0; k < 256; k++) begin
            valid_i = 1'b1; sym_i = 2'b00;
            cyc();
            e = (k % 16 == 15);
            n_tests++;
            if ({valid_o, err_o, sym_o} !== {1'b1, e, (e ? 2'b11 : 2'b00)}) begin
                n_fail++;
                $display("FAIL periodic_sym k=%0d got %b exp %b", k, {valid_o, err_o, sym_o}, {1'b1, e, (e ? 2'b11 : 2'b00)});
            end
            n_tests++;
            if ({busy_o, done_o} !== ((k == 255) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL periodic_busy_done k=%0d got %b", k, {busy_o, done_o});
            end
        end
        n_tests++;
        if (sym_ct_o !== 16'd256 || inj_ct_o !== 16'd16 || bit_ct_o !== 16'd32) begin
            n_fail++;
            $display("FAIL periodic_counts got %0d/%0d/%0d exp 256/16/32", sym_ct_o, inj_ct_o, bit_ct_o);
        end
        valid_i = 1'b1; sym_i = 2'b00;
        cyc();
        valid_i = 1'b0;
        n_tests++;
        if ({valid_o, err_o, sym_o} !== 4'b1000 || sym_ct_o !== 16'd256 || done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL periodic_after_window got %b ct=%0d done=%b exp 1000 ct=256 done=1",
                     {valid_o, err_o, sym_o}, sym_ct_o, done_o);
        end
    endtask

    task automatic test_burst(input logic [3:0] bl, input logic [1:0] mk, input int lo,
                              input int exp_inj, input int exp_bit);
        logic e;
        logic [1:0] s;
        start_run(2'd2, mk, bl, 16'h0, 16'h0, 1'b0, 2'b00);
        for (int k = 0; k < 256; k++) begin
            s = 2'(k);
            valid_i = 1'b1; sym_i = s;
            cyc();
            e = ((k % 16) >= lo);
            n_tests++;
            if ({valid_o, err_o, sym_o} !== {1'b1, e, (e ? (s ^ mk) : s)}) begin
                n_fail++;
                $display("FAIL burst_sym L=%0d k=%0d got %b exp %b", bl, k, {valid_o, err_o, sym_o}, {1'b1, e, (e ? (s ^ mk) : s)});
            end
        end
        valid_i = 1'b0;
        n_tests++;
        if (inj_ct_o !== 16'(exp_inj) || bit_ct_o !== 16'(exp_bit) || done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_counts L=%0d got %0d/%0d done=%b exp %0d/%0d done=1", bl, inj_ct_o, bit_ct_o, done_o, exp_inj, exp_bit);
        end
    endtask

    task automatic test_random_zero();
        start_run(2'd3, 2'b11, 4'd0, 16'h0000, 16'hACE1, 1'b0, 2'b00);
        for (int k = 0; k < 256; k++) begin
            valid_i = 1'b1; sym_i = 2'b01;
            cyc();
            n_tests++;
            if ({valid_o, err_o, sym_o} !== 4'b1001) begin
                n_fail++;
                $display("FAIL random_zero_sym k=%0d got %b exp 1001", k, {valid_o, err_o, sym_o});
            end
        end
        valid_i = 1'b0;
        n_tests++;
        if (inj_ct_o !== 16'd0 || bit_ct_o !== 16'd0 || done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL random_zero_counts got %0d/%0d done=%b exp 0/0 done=1", inj_ct_o, bit_ct_o, done_o);
        end
    endtask

    task automatic test_random(input logic [15:0] sd, input logic [15:0] m0, input int nsym);
        logic [15:0] m;
        logic e;
        int cnt;
        m = m0;
        cnt = 0;
        start_run(2'd3, 2'b10, 4'd0, 16'h8000, sd, 1'b0, 2'b00);
        for (int k = 0; k < nsym; k++) begin
            valid_i = 1'b1; sym_i = 2'b00;
            cyc();
            e = (m < 16'h8000);
            n_tests++;
            if ({valid_o, err_o, sym_o} !== {1'b1, e, (e ? 2'b10 : 2'b00)}) begin
                n_fail++;
                $display("FAIL random_sym seed=%h k=%0d got %b exp %b", sd, k, {valid_o, err_o, sym_o}, {1'b1, e, (e ? 2'b10 : 2'b00)});
            end
            if (e) cnt++;
            m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
        end
        valid_i = 1'b0;
        n_tests++;
        if (inj_ct_o !== 16'(cnt) || bit_ct_o !== 16'(cnt) || sym_ct_o !== 16'(nsym)) begin
            n_fail++;
            $display("FAIL random_counts seed=%h got %0d/%0d/%0d exp %0d/%0d/%0d", sd, sym_ct_o, inj_ct_o, bit_ct_o, nsym, cnt, cnt);
        end
        if (nsym == 256) begin
            n_tests++;
            if (inj_ct_o < 16'd96 || inj_ct_o > 16'd160) begin
                n_fail++;
                $display("FAIL random_range got %0d exp 96..160", inj_ct_o);
            end
        end
    endtask

    task automatic test_gapped();
        logic e;
        logic [1:0] last;
        logic [1:0] s;
        int k;
        last = 2'b00;
        start_run(2'd1, 2'b11, 4'd0, 16'h0, 16'h0, 1'b0, 2'b00);
        for (int c = 0; c < 512; c++) begin
            k = c / 2;
            valid_i = (c % 2 == 0);
            sym_i = (c % 2 == 0) ? 2'(k) : ~2'(k);
            cyc();
            if (c % 2 == 0) begin
                e = (k % 16 == 15);
                s = e ? (2'(k) ^ 2'b11) : 2'(k);
                last = s;
            end else begin
                e = 1'b0;
                s = last;
            end
            n_tests++;
            if ({valid_o, err_o, sym_o} !== {(c % 2 == 0), e, s}) begin
                n_fail++;
                $display("FAIL gapped_sym c=%0d got %b exp %b", c, {valid_o, err_o, sym_o}, {(c % 2 == 0), e, s});
            end
        end
        valid_i = 1'b0;
        n_tests++;
        if (sym_ct_o !== 16'd256 || inj_ct_o !== 16'd16 || bit_ct_o !== 16'd32 || {busy_o, done_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL gapped_counts got %0d/%0d/%0d bd=%b exp 256/16/32 bd=01", sym_ct_o, inj_ct_o, bit_ct_o, {busy_o, done_o});
        end
    endtask

    task automatic test_start_with_valid();
        start_run(2'd1, 2'b11, 4'd0, 16'h0, 16'h0, 1'b0, 2'b00);
        for (int k = 0; k < 15; k++) begin
            valid_i = 1'b1; sym_i = 2'b00;
            cyc();
        end
        start_run(2'd1, 2'b11, 4'd0, 16'h0, 16'h0, 1'b1, 2'b00);
        n_tests++;
        if ({valid_o, err_o, sym_o} !== 4'b1000 || sym_ct_o !== 16'd0 || inj_ct_o !== 16'd0) begin
            n_fail++;
            $display("FAIL start_valid_sym got %b ct=%0d inj=%0d exp 1000 ct=0 inj=0", {valid_o, err_o, sym_o}, sym_ct_o, inj_ct_o);
        end
        for (int k = 0; k < 16; k++) begin
            valid_i = 1'b1; sym_i = 2'b00;
            cyc();
            n_tests++;
            if (err_o !== (k == 15)) begin
                n_fail++;
                $display("FAIL start_valid_err k=%0d got %b exp %b", k, err_o, (k == 15));
            end
        end
        valid_i = 1'b0;
        n_tests++;
        if (sym_ct_o !== 16'd16 || inj_ct_o !== 16'd1) begin
            n_fail++;
            $display("FAIL start_valid_counts got %0d/%0d exp 16/1", sym_ct_o, inj_ct_o);
        end
    endtask

    task automatic test_restart();
        start_run(2'd1, 2'b11, 4'd0, 16'h0, 16'h0, 1'b0, 2'b00);
        for (int k = 0; k < 100; k++) begin
            valid_i = 1'b1; sym_i = 2'b00;
            cyc();
        end
        valid_i = 1'b0;
        n_tests++;
        if (sym_ct_o !== 16'd100 || inj_ct_o !== 16'd6 || bit_ct_o !== 16'd12) begin
            n_fail++;
            $display("FAIL restart_pre got %0d/%0d/%0d exp 100/6/12", sym_ct_o, inj_ct_o, bit_ct_o);
        end
        start_run(2'd2, 2'b01, 4'd2, 16'h0, 16'h0, 1'b0, 2'b00);
        n_tests++;
        if (sym_ct_o !== 16'd0 || inj_ct_o !== 16'd0 || bit_ct_o !== 16'd0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear got %0d/%0d/%0d busy=%b exp 0/0/0 busy=1", sym_ct_o, inj_ct_o, bit_ct_o, busy_o);
        end
        for (int k = 0; k < 16; k++) begin
            valid_i = 1'b1; sym_i = 2'b00;
            cyc();
            n_tests++;
            if ({err_o, sym_o} !== ((k >= 14) ? 3'b101 : 3'b000)) begin
                n_fail++;
                $display("FAIL restart_sym k=%0d got %b", k, {err_o, sym_o});
            end
        end
        valid_i = 1'b0;
        n_tests++;
        if (sym_ct_o !== 16'd16 || inj_ct_o !== 16'd2 || bit_ct_o !== 16'd2) begin
            n_fail++;
            $display("FAIL restart_counts got %0d/%0d/%0d exp 16/2/2", sym_ct_o, inj_ct_o, bit_ct_o);
        end
    endtask

    task automatic test_bypass();
        logic [1:0] s;
        start_run(2'd0, 2'b11, 4'd0, 16'h0, 16'h0, 1'b0, 2'b00);
        for (int k = 0; k < 256; k++) begin
            s = 2'(k * 3 + 1);
            valid_i = 1'b1; sym_i = s;
            cyc();
            n_tests++;
            if ({valid_o, err_o, sym_o} !== {2'b10, s}) begin
                n_fail++;
                $display("FAIL bypass_sym k=%0d got %b exp %b", k, {valid_o, err_o, sym_o}, {2'b10, s});
            end
        end
        valid_i = 1'b0;
        n_tests++;
        if (sym_ct_o !== 16'd256 || inj_ct_o !== 16'd0 || bit_ct_o !== 16'd0 || done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_counts got %0d/%0d/%0d done=%b exp 256/0/0 done=1", sym_ct_o, inj_ct_o, bit_ct_o, done_o);
        end
    endtask

    task automatic test_reset_midrun();
        start_run(2'd1, 2'b11, 4'd0, 16'h0, 16'h0, 1'b0, 2'b00);
        for (int k = 0; k < 50; k++) begin
            valid_i = 1'b1; sym_i = 2'b01;
            cyc();
        end
        valid_i = 1'b1; sym_i = 2'b10;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({valid_o, sym_o, err_o, busy_o, done_o} !== 6'b0 || {sym_ct_o, inj_ct_o, bit_ct_o} !== 48'h0) begin
            n_fail++;
            $display("FAIL midrun_reset got %b ct=%0d/%0d/%0d exp all zero", {valid_o, sym_o, err_o, busy_o, done_o}, sym_ct_o, inj_ct_o, bit_ct_o);
        end
        cyc();
        rst = 1'b0; valid_i = 1'b0;
        cyc();
        n_tests++;
        if ({valid_o, busy_o, done_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrun_after_rst got %b exp 000", {valid_o, busy_o, done_o});
        end
        for (int k = 0; k < 20; k++) begin
            valid_i = 1'b1; sym_i = 2'b11;
            cyc();
            n_tests++;
            if ({valid_o, err_o, sym_o, busy_o, done_o} !== 6'b101100 || sym_ct_o !== 16'd0) begin
                n_fail++;
                $display("FAIL midrun_idle k=%0d got %b ct=%0d exp 101100 ct=0", k, {valid_o, err_o, sym_o, busy_o, done_o}, sym_ct_o);
            end
        end
        valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_burst(4'd3, 2'b01, 13, 48, 48);
        test_burst(4'd0, 2'b01, 15, 16, 16);
        test_burst(4'd15, 2'b11, 1, 240, 480);
        test_random_zero();
        test_random(16'hACE1, 16'hACE1, 256);
        test_random(16'h0000, 16'h0001, 32);
        test_gapped();
        test_start_with_valid();
        test_restart();
        test_bypass();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/viterbi_err_injector.md
# viterbi_err_injector

Parametrised channel error injector placed between the convolutional encoder output and the Viterbi decoder input. It forwards encoded symbols with one cycle of latency and corrupts selected symbols inside a bounded test window. Corruption follows one of four run-time modes: bypass, periodic single-symbol, periodic burst, or LFSR-random. It also keeps saturating statistics counters so a test run can measure decoder correction capability without bench-side bookkeeping.

## Interface
- SYM_W, 2: encoded symbol width in bits.
- N, 4: period exponent; the injection period is 2^N symbols.
- BL_W, 4: width of the burst-length input.
- WINDOW, 256: number of valid symbols per run; injection occurs only inside this window.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start_i  in  1  single-cycle pulse; latches configuration, clears counters, begins a run.
- mode_i  in  2  0 = bypass, 1 = periodic, 2 = burst, 3 = random.
- err_mask_i  in  SYM_W  bits XORed into each corrupted symbol.
- burst_len_i  in  BL_W  burst length for mode 2.
- thresh_i  in  16  random-injection threshold for mode 3.
- seed_i  in  16  LFSR seed for mode 3.
- valid_i  in  1  input symbol valid.
- sym_i  in  SYM_W  input symbol from the encoder.
- valid_o  out  1  output symbol valid, to the decoder enable.
- sym_o  out  SYM_W  output symbol, possibly corrupted.
- err_o  out  1  high with valid_o when sym_o was corrupted.
- sym_ct_o  out  CNT_W  valid symbols accepted in the current run.
- inj_ct_o  out  CNT_W  corrupted symbols in the current run.
- bit_ct_o  out  CNT_W  total flipped bits in the current run.
- busy_o  out  1  high while in RUN.
- done_o  out  1  high once the window completes.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- start_i in any state:
  - latches mode, mask, burst length, threshold and seed;
  - clears all counters;
  - loads the LFSR with seed_i, substituting 0x0001 if seed_i is 0;
  - enters RUN on the next cycle.
- start_i is effective even while RUN is in progress; this is a restart.
- Symbol index k = value of sym_ct_o when a symbol is accepted. A symbol is accepted when valid_i is high in RUN.
- Injection condition for an accepted symbol:
  - Mode 0: never.
  - Mode 1: k[N-1:0] == all ones, i.e. the last symbol of each period.
  - Mode 2: k[N-1:0] >= 2^N - L, where L = burst_len_i. L = 0 is treated as 1; L > 2^N is clipped to 2^N (every symbol).
  - Mode 3: the current LFSR value < thresh_i.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifting toward the MSB with the feedback bit entering bit 0.
  - Advances once per accepted symbol in every mode; the compare uses the value before the advance.
- Corrupted symbol: sym_o = sym_i ^ mask. Otherwise sym_o = sym_i.
- Counter updates per accepted symbol:
  - sym_ct_o increments by 1.
  - When the symbol is corrupted, inj_ct_o increments by 1 and bit_ct_o increments by popcount(mask).
  - All counters saturate at all ones.
- Window end: after the symbol with k = WINDOW-1 is accepted, the FSM enters DONE.
- IDLE and DONE:
  - Symbols pass through unmodified and err_o = 0.
  - Counters hold their values.
  - done_o holds until start_i or rst.

## Timing
- Latency is 1 cycle: valid_o(t+1) = valid_i(t), and sym_o/err_o reflect the symbol accepted at t.
- sym_o holds its last value when valid_o = 0; err_o is 0 whenever valid_o = 0.
- Counters update in the same edge that registers the output, so they are visible together with valid_o.
- busy_o is high from the cycle after start_i until the cycle in which done_o rises. done_o rises the cycle after the last window symbol is accepted.
- start_i coincident with valid_i: start_i has priority. That symbol passes through unmodified, is not counted, and does not advance the LFSR.
- Reset values:
  - valid_o, sym_o, err_o, sym_ct_o, inj_ct_o, bit_ct_o, busy_o and done_o are all 0.
  - Latched configuration is 0; the LFSR is 0x0001.
- Reset mid-run aborts immediately. No partial output is produced after rst deasserts.

## Test plan
- Periodic: mode 1, N=4, mask 11, 256 back-to-back symbols of 00.
  - sym_o = 11 with err_o at k = 15, 31, …, 255; all other symbols 00.
  - Final counts: inj_ct_o = 16, bit_ct_o = 32, sym_ct_o = 256.
  - done_o rises 1 cycle after the last symbol; symbol 257 passes through clean.
- Burst: mode 2, burst_len 3, mask 01.
  - Corruption at k mod 16 ∈ {13, 14, 15}; inj_ct_o = 48, bit_ct_o = 48.
  - Repeat with burst_len 0: same result as mode 1 with a 1-bit mask.
- Random, thresh 0: no injections at all.
- Random, seed 0xACE1, thresh 0x8000, over 256 symbols:
  - inj_ct_o is within 96..160;
  - every err_o matches a bench LFSR model exactly.
- Gapped valid: valid_i alternating 1/0 in mode 1.
  - Only valid cycles are counted; injection positions fall at the same k values as the periodic test.
  - valid_o is valid_i delayed by 1 cycle; sym_o holds during gaps.
- Control edge cases:
  - start_i together with valid_i: that symbol is clean and uncounted.
  - start_i at k = 100: counters clear and the window restarts from k = 0.
  - rst high at k = 50: all outputs go to 0 immediately and the FSM is in IDLE.
  - Mode 0: sym_o equals sym_i delayed, inj_ct_o = 0, done_o after 256 symbols.
